// File: rtl/npu_instr_sequencer.sv
// Instruction sequencer: host-loaded instruction memory, issued one word per cycle
// to the NPU with pause support and a fixed bubble after every MV_MUL issue.
module npu_instr_sequencer #(
    parameter int unsigned                INSTR_WIDTH  = 32,
    parameter int unsigned                OPCODE_WIDTH = 4,
    parameter int unsigned                IMEM_AWIDTH  = 6,
    parameter logic [INSTR_WIDTH-1:0]     NOP_INSTR    = '0,
    parameter logic [OPCODE_WIDTH-1:0]    MVMUL_OPCODE = 4'h4,
    parameter int unsigned                MVMUL_WAIT   = 10
) (
    input  logic                   clk,
    input  logic                   reset_npu,
    input  logic                   imem_we,
    input  logic [IMEM_AWIDTH-1:0] imem_waddr,
    input  logic [INSTR_WIDTH-1:0] imem_wdata,
    input  logic                   start,
    input  logic [IMEM_AWIDTH:0]   num_instr,
    input  logic                   pause,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                 state;
    logic [INSTR_WIDTH-1:0] imem [0:(1 << IMEM_AWIDTH)-1];
    logic [INSTR_WIDTH-1:0] rdata;
    logic [IMEM_AWIDTH-1:0] pc;
    logic [IMEM_AWIDTH-1:0] rd_addr;
    logic [IMEM_AWIDTH:0]   count;
    logic [IMEM_AWIDTH:0]   total;
    logic [31:0]            wait_cnt;
    logic                   fetched;
    logic                   issue_now;
    logic                   last_issue;
    logic                   is_mvmul;

    // rdata always holds imem[pc]; on an issue edge the next word is prefetched
    always_comb begin
        issue_now  = (state == ISSUE) && fetched && !pause;
        rd_addr    = issue_now ? pc + 1'b1 : pc;
        is_mvmul   = (rdata[INSTR_WIDTH-1 -: OPCODE_WIDTH] == MVMUL_OPCODE);
        last_issue = ((count + 1'b1) == total);
        busy       = (state == ISSUE) || (state == WAIT);
    end

    always_ff @(posedge clk) begin
        if (imem_we && (state == IDLE) && !reset_npu)
            imem[imem_waddr] <= imem_wdata;
        rdata <= imem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset_npu) begin
            state       <= IDLE;
            pc          <= '0;
            count       <= '0;
            total       <= '0;
            wait_cnt    <= '0;
            fetched     <= 1'b0;
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            fetched     <= (state == ISSUE) || (state == WAIT);
            case (state)
                IDLE: begin
                    if (start) begin
                        total <= num_instr;
                        pc    <= '0;
                        count <= '0;
                        state <= (num_instr == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_now) begin
                        instruction <= rdata;
                        instr_valid <= 1'b1;
                        pc          <= pc + 1'b1;
                        count       <= count + 1'b1;
                        if (is_mvmul && (MVMUL_WAIT != 0)) begin
                            state    <= WAIT;
                            wait_cnt <= 32'(MVMUL_WAIT);
                        end else if (last_issue) begin
                            state <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (!pause) begin
                        if (wait_cnt == 32'd1) begin
                            wait_cnt <= '0;
                            state    <= (count == total) ? DONE : ISSUE;
                        end else begin
                            wait_cnt <= wait_cnt - 32'd1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_instr_sequencer.sv
// Bench for npu_instr_sequencer: timeline model of issue slots, per-cycle compare,
// plus literal checks on observed run traces.
module tb_npu_instr_sequencer;

    localparam int MVW  = 10;
    localparam int MAXS = 512;

    logic        clk = 1'b0;
    logic        reset_npu = 1'b1;
    logic        imem_we = 1'b0;
    logic [5:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic        start = 1'b0;
    logic [6:0]  num_instr = '0;
    logic        pause = 1'b0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        busy;
    logic        done;

    npu_instr_sequencer #(
        .INSTR_WIDTH(32), .OPCODE_WIDTH(4), .IMEM_AWIDTH(6),
        .NOP_INSTR(32'h0), .MVMUL_OPCODE(4'h4), .MVMUL_WAIT(MVW)
    ) dut (
        .clk(clk), .reset_npu(reset_npu), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .start(start), .num_instr(num_instr), .pause(pause),
        .instruction(instruction), .instr_valid(instr_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [0:63];
    logic [31:0] exp_instr [0:MAXS-1];
    bit          exp_valid [0:MAXS-1];
    bit          exp_busy  [0:MAXS-1];
    bit          exp_done  [0:MAXS-1];
    int          exp_len;

    bit          pmask    [0:MAXS-1];
    bit          we_at    [0:MAXS-1];
    bit          start_at [0:MAXS-1];
    logic [5:0]  mid_addr;
    logic [31:0] mid_data;
    logic [6:0]  mid_num;

    bit chk_on = 0;
    int slot = 0;
    int first_v, last_v, vcount, done_slot;
    int vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (slot %0d): got %h, expected %h", name, slot, act, exp);
        end
    endtask

    // One instruction per slot from slot 2, skipping paused edges; an MV_MUL consumes
    // MVW further unpaused edges before the next issue may happen.
    task automatic build_exp(input int num, input int rst_edge);
        int t, earliest, e, unp;
        logic [31:0] w;
        for (int s = 0; s < MAXS; s++) begin
            exp_instr[s] = '0; exp_valid[s] = 0; exp_busy[s] = 0; exp_done[s] = 0;
        end
        earliest = 2;
        e = 0;
        for (int k = 0; k < num; k++) begin
            t = earliest;
            while (pmask[t]) t++;
            w = model_mem[k % 64];
            exp_instr[t] = w;
            exp_valid[t] = 1;
            e = t;
            if (w[31:28] == 4'h4 && MVW > 0) begin
                unp = 0;
                while (unp < MVW) begin
                    t++;
                    if (!pmask[t]) unp++;
                end
                e = t;
            end
            earliest = t + 1;
        end
        for (int s = 0; s < e; s++) exp_busy[s] = 1;
        exp_done[e + 1] = 1;
        exp_len = e + 3;
        if (rst_edge >= 0 && rst_edge < exp_len) begin
            for (int s = rst_edge; s < MAXS; s++) begin
                exp_instr[s] = '0; exp_valid[s] = 0; exp_busy[s] = 0; exp_done[s] = 0;
            end
            exp_len = rst_edge + 2;
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("instruction", instruction, exp_instr[slot]);
            chk("instr_valid", 32'(instr_valid), 32'(exp_valid[slot]));
            chk("busy", 32'(busy), 32'(exp_busy[slot]));
            chk("done", 32'(done), 32'(exp_done[slot]));
            if (instr_valid) begin
                if (first_v < 0) first_v = slot;
                last_v = slot;
                vcount++;
                vq.push_back(slot);
            end
            if (done) done_slot = slot;
            slot++;
            if (slot >= exp_len) chk_on = 0;
        end
    end

    task automatic clear_stim();
        for (int s = 0; s < MAXS; s++) begin
            pmask[s] = 0; we_at[s] = 0; start_at[s] = 0;
        end
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        imem_we = 1; imem_waddr = a; imem_wdata = d;
        model_mem[a] = d;
        @(negedge clk);
        imem_we = 0;
    endtask

    task automatic run(input int num, input int rst_edge, input bit we0,
                       input logic [5:0] wa0, input logic [31:0] wd0);
        if (we0) model_mem[wa0] = wd0;
        build_exp(num, rst_edge);
        first_v = -1; last_v = -1; vcount = 0; done_slot = -1;
        vq.delete();
        @(negedge clk);
        start = 1; num_instr = 7'(num);
        imem_we = we0; imem_waddr = wa0; imem_wdata = wd0;
        @(posedge clk);
        #1;
        start = 0; imem_we = 0;
        slot = 0; chk_on = 1;
        for (int t = 1; t <= exp_len; t++) begin
            @(negedge clk);
            pause     = pmask[t];
            reset_npu = (t == rst_edge);
            start     = start_at[t];
            if (start_at[t]) num_instr = mid_num;
            imem_we   = we_at[t];
            if (we_at[t]) begin imem_waddr = mid_addr; imem_wdata = mid_data; end
        end
        @(negedge clk);
        pause = 0; reset_npu = 0; start = 0; imem_we = 0;
        if (chk_on) begin
            $display("FAIL run_timeout: compare still active at slot %0d, expected %0d slots", slot, exp_len);
            n_bad++;
            chk_on = 0;
        end
        clear_stim();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stim();
        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        mid_addr = '0; mid_data = '0; mid_num = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset_npu = 0;
        for (int i = 0; i < 64; i++) load(6'(i), 32'h0);

        // four plain words
        for (int i = 0; i < 4; i++) load(6'(i), 32'h1000_00A0 + 32'(i));
        run(4, -1, 0, '0, '0);
        chk("b_first_valid", 32'(first_v), 32'd2);
        chk("b_last_valid", 32'(last_v), 32'd5);
        chk("b_valid_count", 32'(vcount), 32'd4);
        chk("b_done_slot", 32'(done_slot), 32'd6);

        // write and start during a run are ignored
        we_at[3] = 1; mid_addr = 6'd2; mid_data = 32'hBAD0_0002;
        start_at[4] = 1; mid_num = 7'd2;
        run(4, -1, 0, '0, '0);
        run(4, -1, 0, '0, '0);
        chk("m_word2", vq.size() > 2 ? 32'(vq[2]) : 32'hFFFF_FFFF, 32'd4);

        // V_RD, MV_MUL, V_RD
        load(6'd0, 32'h1000_0011); load(6'd1, 32'h4000_0022); load(6'd2, 32'h1000_0033);
        run(3, -1, 0, '0, '0);
        chk("w_valid_count", 32'(vcount), 32'd3);
        chk("w_nop_gap", vq.size() == 3 ? 32'(vq[2] - vq[1] - 1) : 32'hFFFF_FFFF, 32'd10);
        chk("w_span", 32'(last_v - first_v + 1), 32'd13);
        chk("w_done_slot", 32'(done_slot), 32'd15);

        // pause for three cycles in a five word run
        for (int i = 0; i < 5; i++) load(6'(i), 32'h1100_0000 + 32'(i));
        pmask[4] = 1; pmask[5] = 1; pmask[6] = 1;
        run(5, -1, 0, '0, '0);
        chk("p_valid_count", 32'(vcount), 32'd5);
        chk("p_last_valid", 32'(last_v), 32'd9);
        chk("p_done_slot", 32'(done_slot), 32'd10);

        // zero-length run
        run(0, -1, 0, '0, '0);
        chk("z_valid_count", 32'(vcount), 32'd0);
        chk("z_done_slot", 32'(done_slot), 32'd1);

        // trailing MV_MUL wait with a pause inside it
        load(6'd0, 32'h4000_0001);
        pmask[6] = 1;
        run(1, -1, 0, '0, '0);
        chk("t_done_slot", 32'(done_slot), 32'd14);

        // write and start in the same cycle
        run(1, -1, 1, 6'd0, 32'h1234_5678);
        chk("s_first_valid", 32'(first_v), 32'd2);

        // reset after two of six issues, with start/write held during reset
        for (int i = 0; i < 6; i++) load(6'(i), 32'h1200_0000 + 32'(i));
        start_at[4] = 1; mid_num = 7'd3;
        we_at[4] = 1; mid_addr = 6'd0; mid_data = 32'hDEAD_BEEF;
        run(6, 4, 0, '0, '0);
        chk("r_valid_count", 32'(vcount), 32'd2);
        chk("r_done_seen", 32'(done_slot), 32'hFFFF_FFFF);
        run(6, -1, 0, '0, '0);
        chk("r_restart_count", 32'(vcount), 32'd6);

        // run longer than the memory wraps pc
        for (int i = 0; i < 64; i++) load(6'(i), 32'h2000_0000 + 32'(i));
        run(66, -1, 0, '0, '0);
        chk("x_valid_count", 32'(vcount), 32'd66);
        chk("x_done_slot", 32'(done_slot), 32'd68);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
